// File: rtl/display_bank_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_pkg : shared FSM state type and write-mode constants for display_bank
// Revision    : 1.0
// ---------------------------------------------------------------------------
package display_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } bank_state_t;

  localparam int MODE_BROADCAST  = 0;
  localparam int MODE_FIRST_FREE = 1;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/display_bank_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_bank_if : front-end strobe/data bus and display-side status bundle
// Revision        : 1.0
// ---------------------------------------------------------------------------
interface display_bank_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4
);
  logic                 priem;
  logic [WIDTH-1:0]     data_in;
  logic [N-1:0]         set_en;
  logic [N-1:0]         clr;
  logic [N*WIDTH-1:0]   disp;
  logic [N-1:0]         occupied;
  logic                 full;
  logic                 busy;
  logic                 cap_done;
  logic                 cap_hit;

  modport master (
    output priem, data_in, set_en, clr,
    input  disp, occupied, full, busy, cap_done, cap_hit
  );

  modport slave (
    input  priem, data_in, set_en, clr,
    output disp, occupied, full, busy, cap_done, cap_hit
  );
endinterface
`default_nettype wire

// File: rtl/display_bank_strobe_delay.sv
`default_nettype none
// ---------------------------------------------------------------------------
// strobe_delay : priem rising-edge detect plus DELAY countdown, one-cycle capture pulse
// Revision     : 1.0
// ---------------------------------------------------------------------------
module strobe_delay
  import display_pkg::*;
#(
  parameter int DELAY = 2
) (
  input  wire logic clk,
  input  wire logic rst,
  input  wire logic i_priem,
  output logic      o_cap,
  output logic      o_busy
);
  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_WAIT    = WAIT;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;

  logic       r_priem_q;
  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       w_rise;

  assign w_rise = i_priem & ~r_priem_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_priem_q <= 1'b0;
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
    end else begin
      r_priem_q <= i_priem;
      case (r_state)
        ST_IDLE: begin
          // Rises seen in any other state are dropped, not queued.
          if (w_rise) begin
            r_state <= ST_WAIT;
            r_cnt   <= 4'(DELAY - 1);
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) r_state <= ST_CAPTURE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        ST_CAPTURE: r_state <= ST_IDLE;
        default:    r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_cap  = (r_state == ST_CAPTURE);
  assign o_busy = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: rtl/display_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_bank : N-slot display register bank loaded per priem strobe
// Revision     : 1.0   (optional round-robin overwrite: DISPLAY_BANK_OVERWRITE_EN)
// ---------------------------------------------------------------------------
module display_bank
  import display_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DELAY = 2,
  parameter int MODE  = 0
) (
  input  wire logic     clk,
  input  wire logic     rst,
  display_bank_if.slave bus
);
  localparam logic [N-1:0] c_one = {{(N-1){1'b0}}, 1'b1};

  logic                      w_cap;
  logic                      w_busy;
  logic [N-1:0][WIDTH-1:0]   r_slot;
  logic [N-1:0][WIDTH-1:0]   w_slot_nxt;
  logic [N-1:0]              r_occ;
  logic [N-1:0]              w_occ_nxt;
  logic [N-1:0]              w_cand;
  logic [N-1:0]              w_first;
  logic [N-1:0]              w_base_wr;
  logic [N-1:0]              w_wr;
  logic                      w_hit;
  logic                      w_data_nz;
  logic                      r_cap_done;
  logic                      r_cap_hit;

  strobe_delay #(.DELAY(DELAY)) u_strobe (
    .clk     (clk),
    .rst     (rst),
    .i_priem (bus.priem),
    .o_cap   (w_cap),
    .o_busy  (w_busy)
  );

  assign w_data_nz = |bus.data_in;
  assign w_cand    = bus.set_en & ~r_occ & ~bus.clr;
  // Isolate the lowest set bit of the candidate mask.
  assign w_first   = w_cand & (~w_cand + c_one);
  assign w_base_wr = (w_cap && w_data_nz) ?
                     ((MODE == MODE_FIRST_FREE) ? w_first : w_cand) : '0;

`ifdef DISPLAY_BANK_OVERWRITE_EN
  localparam int PTR_W = $clog2(N);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_ow_idx;
  logic             w_ow_found;
  logic             w_ow;

  // Rotating search from the pointer for the first enabled slot.
  always_comb begin
    int j;
    j          = 0;
    w_ow_idx   = '0;
    w_ow_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = int'(r_ptr) + k;
      if (j >= N) j = j - N;
      if (!w_ow_found && bus.set_en[PTR_W'(j)]) begin
        w_ow_found = 1'b1;
        w_ow_idx   = PTR_W'(j);
      end
    end
  end

  assign w_ow  = w_cap & w_data_nz & ~(|w_base_wr) & (|bus.set_en);
  assign w_wr  = w_ow ? (c_one << w_ow_idx) : w_base_wr;
  assign w_hit = (|w_base_wr) | w_ow;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      r_ptr <= '0;
    else if (w_ow) r_ptr <= PTR_W'(wrap_inc(int'(w_ow_idx), N));
  end
`else
  assign w_wr  = w_base_wr;
  assign w_hit = |w_base_wr;
`endif

  // Clear beats a same-edge write; occupancy tracks the next slot value.
  always_comb begin
    w_slot_nxt = r_slot;
    w_occ_nxt  = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.clr[i])   w_slot_nxt[i] = '0;
      else if (w_wr[i]) w_slot_nxt[i] = bus.data_in;
      w_occ_nxt[i] = |w_slot_nxt[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_slot     <= '0;
      r_occ      <= '0;
      r_cap_done <= 1'b0;
      r_cap_hit  <= 1'b0;
    end else begin
      r_slot     <= w_slot_nxt;
      r_occ      <= w_occ_nxt;
      r_cap_done <= w_cap;
      r_cap_hit  <= w_cap & w_hit;
    end
  end

  assign bus.disp     = r_slot;
  assign bus.occupied = r_occ;
  assign bus.full     = &r_occ;
  assign bus.busy     = w_busy;
  assign bus.cap_done = r_cap_done;
  assign bus.cap_hit  = r_cap_hit;

endmodule
`default_nettype wire

// File: tb/tb_display_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_display_bank : directed bench, MODE 0 and MODE 1 banks checked against a slot model
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_display_bank;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int DELAY = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  display_bank_if #(.WIDTH(WIDTH), .N(N)) if0 ();
  display_bank_if #(.WIDTH(WIDTH), .N(N)) if1 ();

  assign if1.priem   = if0.priem;
  assign if1.data_in = if0.data_in;
  assign if1.set_en  = if0.set_en;
  assign if1.clr     = if0.clr;

  display_bank #(.WIDTH(WIDTH), .N(N), .DELAY(DELAY), .MODE(0)) u_dut0 (
    .clk(clk), .rst(rst), .bus(if0));
  display_bank #(.WIDTH(WIDTH), .N(N), .DELAY(DELAY), .MODE(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus(if1));

  int n_tests = 0;
  int n_fail  = 0;

  // Model: slot contents per bank, one shared capture schedule.
  logic [7:0] m_slot [2][N];
  int         m_ptr  [2];
  bit         m_done [2];
  bit         m_hit  [2];
  int         m_cap_at = -1;
  int         m_edge   = 0;
  bit         m_prev   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_disp(input int md);
    return {m_slot[md][3], m_slot[md][2], m_slot[md][1], m_slot[md][0]};
  endfunction

  function automatic logic [3:0] m_occ(input int md);
    logic [3:0] o;
    for (int i = 0; i < N; i++) o[i] = (m_slot[md][i] != 8'h00);
    return o;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      for (int i = 0; i < N; i++) m_slot[md][i] = 8'h00;
      m_ptr[md]  = 0;
      m_done[md] = 1'b0;
      m_hit[md]  = 1'b0;
    end
    m_cap_at = -1;
    m_prev   = 1'b0;
  endtask

  task automatic model_bank(input int md, input bit do_cap);
    bit wr [N];
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < N; i++) wr[i] = 1'b0;
    if (do_cap && if0.data_in != 8'h00) begin
      for (int i = 0; i < N; i++)
        if (if0.set_en[i] && m_slot[md][i] == 8'h00 && !if0.clr[i] && !(md == 1 && hit)) begin
          wr[i] = 1'b1;
          hit   = 1'b1;
        end
`ifdef DISPLAY_BANK_OVERWRITE_EN
      if (!hit && if0.set_en != 4'b0000) begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (m_ptr[md] + k) % N;
          if (!hit && if0.set_en[j]) begin
            wr[j]     = 1'b1;
            hit       = 1'b1;
            m_ptr[md] = (j + 1) % N;
          end
        end
      end
`endif
    end
    for (int i = 0; i < N; i++) begin
      if (if0.clr[i])  m_slot[md][i] = 8'h00;
      else if (wr[i])  m_slot[md][i] = if0.data_in;
    end
    m_done[md] = do_cap;
    m_hit[md]  = do_cap && hit;
  endtask

  task automatic model_edge();
    bit do_cap;
    m_edge++;
    do_cap = (m_cap_at == m_edge);
    model_bank(0, do_cap);
    model_bank(1, do_cap);
    if (if0.priem && !m_prev && m_cap_at < 0) m_cap_at = m_edge + DELAY + 1;
    if (do_cap) m_cap_at = -1;
    m_prev = if0.priem;
  endtask

  always @(negedge clk) begin
    check("disp0",  if0.disp,     m_disp(0));
    check("occ0",   {28'd0, if0.occupied}, {28'd0, m_occ(0)});
    check("full0",  {31'd0, if0.full},     {31'd0, &m_occ(0)});
    check("busy0",  {31'd0, if0.busy},     {31'd0, m_cap_at >= 0});
    check("done0",  {31'd0, if0.cap_done}, {31'd0, m_done[0]});
    check("hit0",   {31'd0, if0.cap_hit},  {31'd0, m_hit[0]});
    check("disp1",  if1.disp,     m_disp(1));
    check("occ1",   {28'd0, if1.occupied}, {28'd0, m_occ(1)});
    check("full1",  {31'd0, if1.full},     {31'd0, &m_occ(1)});
    check("busy1",  {31'd0, if1.busy},     {31'd0, m_cap_at >= 0});
    check("done1",  {31'd0, if1.cap_done}, {31'd0, m_done[1]});
    check("hit1",   {31'd0, if1.cap_hit},  {31'd0, m_hit[1]});
  end

  task automatic step();
    @(posedge clk);
    if (rst) model_edge();
    @(negedge clk);
    #2;
  endtask

  task automatic capture(input logic [7:0] d, input logic [3:0] en, input logic [3:0] clr_cap);
    if0.data_in = d;
    if0.set_en  = en;
    if0.priem   = 1'b1;
    step();
    if0.priem   = 1'b0;
    repeat (DELAY) step();
    if0.clr     = clr_cap;
    step();
    if0.clr     = 4'b0000;
  endtask

  task automatic clear_all();
    if0.clr = 4'b1111;
    step();
    if0.clr = 4'b0000;
  endtask

  initial begin
    int done_cnt;
    bit pat [8];
    if0.priem   = 1'b0;
    if0.data_in = 8'h00;
    if0.set_en  = 4'b0000;
    if0.clr     = 4'b0000;
    model_reset();
    step();
    step();
    check("reset_disp", if0.disp, 32'h0);
    check("reset_busy", {31'd0, if0.busy}, 32'd0);
    rst = 1'b1;

    // Broadcast to slots 0 and 2; first-free bank takes slot 0 only.
    capture(8'h3C, 4'b0101, 4'b0000);
    check("t1_disp0", if0.disp, 32'h003C003C);
    check("t1_done",  {31'd0, if0.cap_done}, 32'd1);
    check("t1_hit",   {31'd0, if0.cap_hit},  32'd1);
    check("t1_disp1", if1.disp, 32'h0000003C);

    capture(8'h11, 4'b1111, 4'b0000);
    check("t2_disp1", if1.disp, 32'h0000113C);
    check("t2_occ1",  {28'd0, if1.occupied}, 32'h3);
    check("t2_disp0", if0.disp, 32'h113C113C);
    check("t2_full0", {31'd0, if0.full}, 32'd1);

    capture(8'h00, 4'b1111, 4'b0000);
    check("t3_done",  {31'd0, if1.cap_done}, 32'd1);
    check("t3_hit",   {31'd0, if1.cap_hit},  32'd0);
    check("t3_disp1", if1.disp, 32'h0000113C);

    clear_all();
    check("clr_disp0", if0.disp, 32'h0);

    // A second rise during WAIT must not start another capture.
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    if0.data_in = 8'h22;
    if0.set_en  = 4'b0001;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if0.priem = pat[i];
      step();
      if (if0.cap_done) done_cnt++;
    end
    check("t4_caps", done_cnt, 32'd1);
    check("t4_disp0", if0.disp, 32'h00000022);

    clear_all();
    capture(8'h55, 4'b0010, 4'b0010);
    check("t5_disp0", if0.disp, 32'h0);
    check("t5_occ1",  {31'd0, if0.occupied[1]}, 32'd0);
`ifdef DISPLAY_BANK_OVERWRITE_EN
    check("t5_hit",   {31'd0, if0.cap_hit}, 32'd1);
`else
    check("t5_hit",   {31'd0, if0.cap_hit}, 32'd0);
`endif

    rst = 1'b0;
    model_reset();
    step();
    rst = 1'b1;
    capture(8'h77, 4'b1111, 4'b0000);
    check("t6_fill", if0.disp, 32'h77777777);
    capture(8'hA5, 4'b1111, 4'b0000);
`ifdef DISPLAY_BANK_OVERWRITE_EN
    check("t6_disp", if0.disp, 32'h777777A5);
    check("t6_hit",  {31'd0, if0.cap_hit}, 32'd1);
    capture(8'hB6, 4'b1111, 4'b0000);
    check("t6_ptr",  if0.disp, 32'h7777B6A5);
`else
    check("t6_disp", if0.disp, 32'h77777777);
    check("t6_hit",  {31'd0, if0.cap_hit}, 32'd0);
    check("t6_done", {31'd0, if0.cap_done}, 32'd1);
`endif

    clear_all();
    if0.data_in = 8'h99;
    if0.set_en  = 4'b1111;
    if0.priem   = 1'b1;
    step();
    check("t7_busy", {31'd0, if0.busy}, 32'd1);
    rst = 1'b0;
    if0.priem = 1'b0;
    model_reset();
    #1;
    check("t7_disp",   if0.disp, 32'h0);
    check("t7_busy0",  {31'd0, if0.busy}, 32'd0);
    check("t7_occ",    {28'd0, if0.occupied}, 32'h0);
    step();
    rst = 1'b1;
    done_cnt = 0;
    repeat (6) begin
      step();
      if (if0.cap_done) done_cnt++;
    end
    check("t7_nocap", done_cnt, 32'd0);
    check("t7_end",   if0.disp, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
